// File: rtl/spike_mon_pkg.sv
// Shared types, constants and helpers for the spike rate monitor.
package spike_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        CAND,
        BURST
    } mon_state_t;

    // Histogram bin upper bounds, as multiples of the burst ISI threshold.
    localparam int unsigned HIST_MUL0 = 1;
    localparam int unsigned HIST_MUL1 = 4;
    localparam int unsigned HIST_MUL2 = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] mx;
        mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= mx) ? mx : v + 32'd1;
    endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Rising-edge detector for the neuron spike level; evt is combinational,
// spike_evt is its registered copy, qualified by the count enable.
module spike_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic spike,
    output logic evt,
    output logic spike_evt
);

    logic spike_q;

    assign evt = spike & ~spike_q;

    // spike_q tracks the input even while disabled so re-enable never sees a stale edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q   <= 1'b0;
            spike_evt <= 1'b0;
        end else begin
            spike_q   <= spike;
            spike_evt <= evt & en;
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Windowed firing rate, inter-spike interval and burst detection for one neuron.
// Optional ISI histogram readback when SPIKE_MON_HIST_EN is defined.
module spike_rate_monitor
    import spike_mon_pkg::*;
#(
    parameter int unsigned WIN_W     = 16,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ISI_W     = 12,
    parameter int unsigned BURST_ISI = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             spike,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic [ISI_W-1:0] last_isi,
    output logic             isi_valid,
    output logic             burst,
    output logic             spike_evt
`ifdef SPIKE_MON_HIST_EN
    ,
    input  logic [1:0]       hist_sel,
    output logic [7:0]       hist_count
`endif
);

    logic             evt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] spk_next;
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] isi_inc;
    logic             isi_short;
    logic             isi_sat;
    logic             win_close;
    mon_state_t       state;

    spike_edge_det u_edge (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .spike     (spike),
        .evt       (evt),
        .spike_evt (spike_evt)
    );

    always_comb begin
        spk_next  = evt ? CNT_W'(sat_inc(32'(spk_cnt), CNT_W)) : spk_cnt;
        isi_inc   = ISI_W'(sat_inc(32'(isi_cnt), ISI_W));
        // Elapsed interval counting the current cycle is isi_cnt+1.
        isi_short = 32'(isi_cnt) < BURST_ISI;
        isi_sat   = (isi_cnt == '1);
        win_close = (window_len != '0) && (win_cnt >= window_len - WIN_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt    <= '0;
            spk_cnt    <= '0;
            isi_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            last_isi   <= '0;
            isi_valid  <= 1'b0;
        end else if (en) begin
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
            if (window_len == '0) begin
                win_cnt <= '0;
                spk_cnt <= '0;
            end else if (win_close) begin
                rate       <= spk_next;
                rate_valid <= 1'b1;
                win_cnt    <= '0;
                spk_cnt    <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                spk_cnt <= spk_next;
            end

            if (evt) begin
                isi_cnt <= '0;
                if (state != IDLE) begin
                    last_isi  <= isi_inc;
                    isi_valid <= 1'b1;
                end
            end else begin
                isi_cnt <= isi_inc;
            end
        end else begin
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            burst <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (evt) state <= TRACK;
                end
                TRACK: begin
                    if (evt && isi_short) state <= CAND;
                    else if (!evt && isi_sat) state <= IDLE;
                end
                CAND: begin
                    if (evt) begin
                        if (isi_short) begin
                            state <= BURST;
                            burst <= 1'b1;
                        end else begin
                            state <= TRACK;
                        end
                    end else if (isi_sat) begin
                        state <= IDLE;
                    end
                end
                BURST: begin
                    // Leave once the gap exceeds the burst threshold, with or without a late event.
                    if (!isi_short) begin
                        state <= TRACK;
                        burst <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    burst <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPIKE_MON_HIST_EN
    logic [7:0] hist_bin [4];
    logic [1:0] hist_idx;

    always_comb begin
        if (32'(isi_inc) <= BURST_ISI * HIST_MUL0)      hist_idx = 2'd0;
        else if (32'(isi_inc) <= BURST_ISI * HIST_MUL1) hist_idx = 2'd1;
        else if (32'(isi_inc) <= BURST_ISI * HIST_MUL2) hist_idx = 2'd2;
        else                                            hist_idx = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) hist_bin[i] <= '0;
        end else if (en && evt && state != IDLE) begin
            hist_bin[hist_idx] <= 8'(sat_inc(32'(hist_bin[hist_idx]), 8));
        end
    end

    assign hist_count = hist_bin[hist_sel];
`endif

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed self-checking bench for spike_rate_monitor (histogram checks when SPIKE_MON_HIST_EN is defined).
module tb_spike_rate_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        spike;
    logic [15:0] window_len;
    logic [7:0]  rate;
    logic        rate_valid;
    logic [11:0] last_isi;
    logic        isi_valid;
    logic        burst;
    logic        spike_evt;
`ifdef SPIKE_MON_HIST_EN
    logic [1:0]  hist_sel;
    logic [7:0]  hist_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_rate_monitor #(
        .WIN_W     (16),
        .CNT_W     (8),
        .ISI_W     (12),
        .BURST_ISI (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .spike      (spike),
        .window_len (window_len),
        .rate       (rate),
        .rate_valid (rate_valid),
        .last_isi   (last_isi),
        .isi_valid  (isi_valid),
        .burst      (burst),
        .spike_evt  (spike_evt)
`ifdef SPIKE_MON_HIST_EN
        ,
        .hist_sel   (hist_sel),
        .hist_count (hist_count)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] wl);
        reset = 1'b1; en = 1'b1; spike = 1'b0; window_len = wl;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; spike = 1'b1; window_len = 16'd3;
        tick; tick; tick;
        total += 6;
        if (rate !== 8'd0)      begin bad++; $display("FAIL reset_rate: got %0d want 0", rate); end
        if (rate_valid !== 1'b0) begin bad++; $display("FAIL reset_rate_valid: got %b want 0", rate_valid); end
        if (last_isi !== 12'd0) begin bad++; $display("FAIL reset_last_isi: got %0d want 0", last_isi); end
        if (isi_valid !== 1'b0) begin bad++; $display("FAIL reset_isi_valid: got %b want 0", isi_valid); end
        if (burst !== 1'b0)     begin bad++; $display("FAIL reset_burst: got %b want 0", burst); end
        if (spike_evt !== 1'b0) begin bad++; $display("FAIL reset_spike_evt: got %b want 0", spike_evt); end
        spike = 1'b0;
    endtask

    task automatic test_idle_window;
        int isi_hits = 0;
        int burst_hits = 0;
        logic exp_rv;
        do_reset(16'd100);
        for (int n = 1; n <= 300; n++) begin
            tick;
            exp_rv = (n % 100 == 0);
            total++;
            if (rate_valid !== exp_rv) begin
                bad++; $display("FAIL idle_rate_valid n=%0d: got %b want %b", n, rate_valid, exp_rv);
            end
            if (exp_rv) begin
                total++;
                if (rate !== 8'd0) begin bad++; $display("FAIL idle_rate n=%0d: got %0d want 0", n, rate); end
            end
            isi_hits += int'(isi_valid);
            burst_hits += int'(burst);
        end
        total += 2;
        if (isi_hits != 0)   begin bad++; $display("FAIL idle_isi_valid: got %0d pulses want 0", isi_hits); end
        if (burst_hits != 0) begin bad++; $display("FAIL idle_burst: got %0d cycles want 0", burst_hits); end
    endtask

    task automatic test_regular_spikes;
        logic exp_rv, exp_iv, exp_ev;
        do_reset(16'd100);
        for (int n = 1; n <= 300; n++) begin
            spike = (n % 10 == 1);
            tick;
            exp_rv = (n % 100 == 0);
            exp_iv = (n % 10 == 1) && (n > 1);
            exp_ev = (n % 10 == 1);
            total += 4;
            if (rate_valid !== exp_rv) begin bad++; $display("FAIL reg_rate_valid n=%0d: got %b want %b", n, rate_valid, exp_rv); end
            if (isi_valid !== exp_iv)  begin bad++; $display("FAIL reg_isi_valid n=%0d: got %b want %b", n, isi_valid, exp_iv); end
            if (spike_evt !== exp_ev)  begin bad++; $display("FAIL reg_spike_evt n=%0d: got %b want %b", n, spike_evt, exp_ev); end
            if (burst !== 1'b0)        begin bad++; $display("FAIL reg_burst n=%0d: got %b want 0", n, burst); end
            if (exp_rv) begin
                total++;
                if (rate !== 8'd10) begin bad++; $display("FAIL reg_rate n=%0d: got %0d want 10", n, rate); end
            end
            if (exp_iv) begin
                total++;
                if (last_isi !== 12'd10) begin bad++; $display("FAIL reg_last_isi n=%0d: got %0d want 10", n, last_isi); end
            end
        end
        spike = 1'b0;
    endtask

    task automatic test_burst;
        int iv_count = 0;
        logic exp_b;
        do_reset(16'd0);
        for (int n = 1; n <= 60; n++) begin
            spike = (n == 1 || n == 6 || n == 11 || n == 16);
            tick;
            exp_b = (n >= 11 && n < 25);
            total++;
            if (burst !== exp_b) begin bad++; $display("FAIL burst_level n=%0d: got %b want %b", n, burst, exp_b); end
            if (isi_valid) begin
                iv_count++;
                total++;
                if (last_isi !== 12'd5) begin bad++; $display("FAIL burst_last_isi n=%0d: got %0d want 5", n, last_isi); end
            end
        end
        total++;
        if (iv_count != 3) begin bad++; $display("FAIL burst_isi_count: got %0d want 3", iv_count); end
        spike = 1'b0;
    endtask

    task automatic test_burst_boundary;
        logic exp_b;
        do_reset(16'd0);
        for (int n = 1; n <= 30; n++) begin
            spike = (n == 1 || n == 9 || n == 17 || n == 26);
            tick;
            exp_b = (n >= 17 && n < 26);
            total++;
            if (burst !== exp_b) begin bad++; $display("FAIL bnd_burst n=%0d: got %b want %b", n, burst, exp_b); end
            if (n == 9 || n == 26) begin
                total += 2;
                if (isi_valid !== 1'b1) begin bad++; $display("FAIL bnd_isi_valid n=%0d: got %b want 1", n, isi_valid); end
                if (last_isi !== ((n == 9) ? 12'd8 : 12'd9)) begin
                    bad++; $display("FAIL bnd_last_isi n=%0d: got %0d want %0d", n, last_isi, (n == 9) ? 8 : 9);
                end
            end
        end
        spike = 1'b0;
    endtask

    task automatic test_held_spike;
        int ev1 = 0;
        int ev2 = 0;
        int iv = 0;
        do_reset(16'd0);
        spike = 1'b1;
        for (int n = 0; n < 20; n++) begin tick; ev1 += int'(spike_evt); end
        en = 1'b0;
        for (int n = 0; n < 3; n++) begin tick; ev2 += int'(spike_evt); iv += int'(isi_valid); end
        en = 1'b1;
        for (int n = 0; n < 5; n++) begin tick; ev2 += int'(spike_evt); iv += int'(isi_valid); end
        total += 3;
        if (ev1 != 1) begin bad++; $display("FAIL held_evt_count: got %0d want 1", ev1); end
        if (ev2 != 0) begin bad++; $display("FAIL held_reenable_evt: got %0d want 0", ev2); end
        if (iv != 0)  begin bad++; $display("FAIL held_isi_valid: got %0d want 0", iv); end
        spike = 1'b0;
        tick;
    endtask

    task automatic test_enable_freeze;
        logic exp_rv;
        do_reset(16'd10);
        for (int n = 1; n <= 17; n++) begin
            en = !(n >= 6 && n <= 12);
            spike = (n == 8 || n == 9);
            tick;
            exp_rv = (n == 17);
            total += 2;
            if (rate_valid !== exp_rv) begin bad++; $display("FAIL frz_rate_valid n=%0d: got %b want %b", n, rate_valid, exp_rv); end
            if (spike_evt !== 1'b0)    begin bad++; $display("FAIL frz_spike_evt n=%0d: got %b want 0", n, spike_evt); end
        end
        total++;
        if (rate !== 8'd0) begin bad++; $display("FAIL frz_rate: got %0d want 0", rate); end
        en = 1'b1;
    endtask

    task automatic test_window_close_evt;
        logic exp_rv;
        do_reset(16'd50);
        for (int n = 1; n <= 100; n++) begin
            spike = (n == 10 || n == 50 || n == 60);
            tick;
            exp_rv = (n == 50 || n == 100);
            total++;
            if (rate_valid !== exp_rv) begin bad++; $display("FAIL wce_rate_valid n=%0d: got %b want %b", n, rate_valid, exp_rv); end
            if (exp_rv) begin
                total++;
                if (rate !== ((n == 50) ? 8'd2 : 8'd1)) begin
                    bad++; $display("FAIL wce_rate n=%0d: got %0d want %0d", n, rate, (n == 50) ? 2 : 1);
                end
            end
        end
        for (int n = 101; n <= 124; n++) begin
            spike = (n == 110);
            tick;
        end
        spike = 1'b0;
        reset = 1'b1;
        tick;
        total += 4;
        if (rate !== 8'd0)       begin bad++; $display("FAIL mid_reset_rate: got %0d want 0", rate); end
        if (last_isi !== 12'd0)  begin bad++; $display("FAIL mid_reset_last_isi: got %0d want 0", last_isi); end
        if (rate_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_rate_valid: got %b want 0", rate_valid); end
        if (burst !== 1'b0)      begin bad++; $display("FAIL mid_reset_burst: got %b want 0", burst); end
        reset = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            tick;
            exp_rv = (n == 50);
            total++;
            if (rate_valid !== exp_rv) begin bad++; $display("FAIL post_reset_rate_valid n=%0d: got %b want %b", n, rate_valid, exp_rv); end
        end
        total++;
        if (rate !== 8'd0) begin bad++; $display("FAIL post_reset_rate: got %0d want 0", rate); end
    endtask

    task automatic test_window_change;
        logic exp_rv;
        do_reset(16'd100);
        for (int n = 1; n <= 51; n++) begin
            if (n == 31) window_len = 16'd20;
            spike = (n == 5);
            tick;
            exp_rv = (n == 31 || n == 51);
            total++;
            if (rate_valid !== exp_rv) begin bad++; $display("FAIL wchg_rate_valid n=%0d: got %b want %b", n, rate_valid, exp_rv); end
            if (exp_rv) begin
                total++;
                if (rate !== ((n == 31) ? 8'd1 : 8'd0)) begin
                    bad++; $display("FAIL wchg_rate n=%0d: got %0d want %0d", n, rate, (n == 31) ? 1 : 0);
                end
            end
        end
        spike = 1'b0;
    endtask

    task automatic test_rate_saturation;
        do_reset(16'd600);
        for (int n = 1; n <= 600; n++) begin
            spike = (n % 2 == 1);
            tick;
        end
        total += 2;
        if (rate_valid !== 1'b1) begin bad++; $display("FAIL sat_rate_valid: got %b want 1", rate_valid); end
        if (rate !== 8'd255)     begin bad++; $display("FAIL sat_rate: got %0d want 255", rate); end
        spike = 1'b0;
    endtask

`ifdef SPIKE_MON_HIST_EN
    task automatic test_histogram;
        logic [7:0] exp_bin [4];
        do_reset(16'd0);
        hist_sel = 2'd0;
        for (int n = 1; n <= 430; n++) begin
            spike = (n == 1 || n == 6 || n == 26 || n == 126 || n == 426);
            tick;
        end
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s);
            #1;
            total++;
            if (hist_count !== 8'd1) begin bad++; $display("FAIL hist_bin%0d: got %0d want 1", s, hist_count); end
        end
        for (int n = 431; n <= 1930; n++) begin
            spike = ((n - 431) % 5 == 0);
            tick;
        end
        spike = 1'b0;
        exp_bin[0] = 8'd255; exp_bin[1] = 8'd1; exp_bin[2] = 8'd1; exp_bin[3] = 8'd1;
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s);
            #1;
            total++;
            if (hist_count !== exp_bin[s]) begin
                bad++; $display("FAIL hist_sat_bin%0d: got %0d want %0d", s, hist_count, exp_bin[s]);
            end
        end
    endtask
`endif

    initial begin
`ifdef SPIKE_MON_HIST_EN
        hist_sel = 2'd0;
`endif
        test_reset;
        test_idle_window;
        test_regular_spikes;
        test_burst;
        test_burst_boundary;
        test_held_spike;
        test_enable_freeze;
        test_window_close_evt;
        test_window_change;
        test_rate_saturation;
`ifdef SPIKE_MON_HIST_EN
        test_histogram;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
